// File: rtl/xcr_tx_if.sv
// Signal bundle for xcr_tx: upstream valid/ready stream, credit link and status.
// The slave modport is the transmitter's view; master is the environment's view.
interface xcr_tx_if #(
    parameter int unsigned D_WIDTH = 16,
    parameter int unsigned CREDITS = 4
);
    localparam int unsigned CW = $clog2(CREDITS + 1);

    logic               vldi;
    logic [D_WIDTH-1:0] datai;
    logic               rdyi;
    logic               link_vld;
    logic [D_WIDTH-1:0] link_data;
    logic               crd_rtn;
    logic [CW-1:0]      crd_cnt;
    logic               link_idle;
    logic               crd_err;

    modport master (
        output vldi, datai, crd_rtn,
        input  rdyi, link_vld, link_data, crd_cnt, link_idle, crd_err
    );

    modport slave (
        input  vldi, datai, crd_rtn,
        output rdyi, link_vld, link_data, crd_cnt, link_idle, crd_err
    );
endinterface

// File: rtl/xcr_tx.sv
// Credit-based link transmitter: registered single-beat flits onto the link,
// gated by a credit counter that mirrors free entries in the receiver buffer.
module xcr_tx #(
    parameter int unsigned D_WIDTH = 16,
    parameter int unsigned CREDITS = 4
) (
    input logic    clk,
    input logic    rstn,
    xcr_tx_if.slave bus
);
    localparam int unsigned   CW     = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CrdMax = CW'(CREDITS);
    localparam logic [CW-1:0] CrdOne = CW'(1);

    logic [CW-1:0]      crd_cnt_q, crd_cnt_d;
    logic               link_vld_q, link_vld_d;
    logic [D_WIDTH-1:0] link_data_q, link_data_d;
    logic               crd_err_q, crd_err_d;
    logic               send;

    // Ready comes from registered state only, so no comb path from vldi/crd_rtn.
    assign bus.rdyi = (crd_cnt_q != '0);
    assign send     = bus.vldi & bus.rdyi;

    always_comb begin
        crd_cnt_d   = crd_cnt_q;
        crd_err_d   = crd_err_q;
        link_vld_d  = send;
        link_data_d = send ? bus.datai : link_data_q;

        unique case ({send, bus.crd_rtn})
            2'b10: crd_cnt_d = crd_cnt_q - CrdOne;
            2'b01: begin
                if (crd_cnt_q == CrdMax) begin
                    crd_err_d = 1'b1;
                end else begin
                    crd_cnt_d = crd_cnt_q + CrdOne;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crd_cnt_q   <= CrdMax;
            link_vld_q  <= 1'b0;
            link_data_q <= '0;
            crd_err_q   <= 1'b0;
        end else begin
            crd_cnt_q   <= crd_cnt_d;
            link_vld_q  <= link_vld_d;
            link_data_q <= link_data_d;
            crd_err_q   <= crd_err_d;
        end
    end

    assign bus.link_vld  = link_vld_q;
    assign bus.link_data = link_data_q;
    assign bus.crd_cnt   = crd_cnt_q;
    assign bus.crd_err   = crd_err_q;
    assign bus.link_idle = (crd_cnt_q == CrdMax) && !link_vld_q;
endmodule

// File: doc/xcr_tx.md
# xcr_tx

Credit-based link transmitter for the switch fabric. It takes a valid/ready stream from a local source, drives registered single-beat flits onto a point-to-point link, and tracks receiver buffer space with a credit counter. It is the sending end of links whose receiving end is a fixed-depth buffer that returns one credit per freed entry. It sits between an output port's valid/ready slice and the physical inter-switch link.

## Interface
- D_WIDTH, 16, flit data width
- CREDITS, 4, receiver buffer depth; initial and maximum credit count (legal range 1..255)
- CW, $clog2(CREDITS+1), credit counter width (derived, do not override)

- clk  input  1  clock; all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- vldi  input  1  upstream flit valid
- datai  input  D_WIDTH  upstream flit data
- rdyi  output  1  upstream ready; transfer occurs when vldi & rdyi
- link_vld  output  1  registered flit valid toward receiver; one-cycle pulse per flit
- link_data  output  D_WIDTH  registered flit data
- crd_rtn  input  1  one credit returned by receiver this cycle
- crd_cnt  output  CW  current credits available
- link_idle  output  1  crd_cnt == CREDITS and link_vld == 0
- crd_err  output  1  sticky protocol-error flag

## Operation
- Reset (async assert, sync-to-clk deassert expected upstream): crd_cnt = CREDITS, link_vld = 0, link_data = 0, crd_err = 0. Outputs take reset values immediately on rstn low.
- rdyi = (crd_cnt != 0); depends only on registered state, never on vldi or crd_rtn in the same cycle.
- Send: vldi & rdyi -> next cycle link_vld = 1, link_data = datai; crd_cnt decrements.
- No send -> next cycle link_vld = 0; link_data holds last value.
- Credit return: crd_rtn -> crd_cnt increments.
- Simultaneous send and crd_rtn: crd_cnt unchanged; send proceeds.
- crd_rtn while crd_cnt == CREDITS and no send in that cycle: overflow; crd_cnt saturates at CREDITS, crd_err set.
- crd_err clears only on reset.
- Counter update is a 3-way case {send, crd_rtn}: 10 -> -1, 01 -> +1 (saturating), 00/11 -> hold. Arithmetic is CW bits wide, unsigned; underflow is impossible because send requires crd_cnt != 0.
- Data is never dropped or duplicated. Each accepted flit produces exactly one link_vld pulse.
- The link has no backpressure; the receiver must absorb any flit sent with a credit.

## Timing
- Latency datai -> link_data: 1 cycle. Throughput: 1 flit/cycle while credits remain.
- Credit turnaround: a crd_rtn at cycle N makes rdyi high at N+1 if crd_cnt was 0.
- Zero credits: rdyi low from the cycle after the last credit is consumed; upstream holds vldi/datai stable.
- Sustained full rate needs CREDITS >= receiver round-trip latency; smaller CREDITS throttles but stays correct.
- Reset mid-operation: in-flight link_vld is cleared at once, and credits reinitialise to CREDITS. The receiver must be reset in the same domain.

## Test plan
- Reset, CREDITS=4: hold rstn low, then release -> crd_cnt=4, rdyi=1, link_vld=0, link_data=0, crd_err=0, link_idle=1.
- Burst without returns: vldi=1 with data 0x0001..0x0006 -> link_vld high for 4 consecutive cycles carrying 0x0001..0x0004, each one cycle after acceptance; rdyi=0 after the 4th; crd_cnt=0; 0x0005 held upstream.
- Resume: from the previous state, one crd_rtn pulse -> rdyi=1 next cycle; 0x0005 sent; crd_cnt back to 0.
- Simultaneous: crd_cnt=2, vldi=1 and crd_rtn=1 for 3 cycles -> 3 flits sent, crd_cnt stays 2 throughout.
- Overflow: idle with crd_cnt=4, pulse crd_rtn -> crd_cnt stays 4, crd_err=1 and remains 1 until rstn.
- Async reset mid-burst: assert rstn low between clock edges while link_vld=1 and crd_cnt=1 -> link_vld=0 and crd_cnt=4 immediately, without waiting for a clock edge.
